// File: rtl/brick_pkg.sv
// Shared geometry defaults, brick colours, FSM state type and brick placement
// helper for the brick row.
package brick_pkg;

  localparam int DEF_NUM_BLOCKS = 10;
  localparam int DEF_BLOCK_W    = 60;
  localparam int DEF_BLOCK_H    = 20;
  localparam int DEF_ROW_Y      = 40;
  localparam int DEF_X0         = 2;
  localparam int DEF_PITCH      = 64;

  localparam logic [23:0] COLOR_EVEN  = 24'hff4000;
  localparam logic [23:0] COLOR_ODD   = 24'h00a0ff;
  localparam logic [23:0] COLOR_BLACK = 24'h000000;

  typedef enum logic {
    PLAY  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Left edge of brick idx.
  function automatic logic [9:0] brick_x(input int idx, input int x0, input int pitch);
    return 10'(x0 + idx * pitch);
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle overlap test; sums widened to 11 bits
// so a rectangle near the right/bottom edge cannot wrap.
module rect_overlap (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] aw,
  input  logic [9:0] ah,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] bw,
  input  logic [9:0] bh,
  output logic       hit
);

  logic [10:0] a_right, a_bottom, b_right, b_bottom;

  assign a_right  = {1'b0, ax} + {1'b0, aw};
  assign a_bottom = {1'b0, ay} + {1'b0, ah};
  assign b_right  = {1'b0, bx} + {1'b0, bw};
  assign b_bottom = {1'b0, by} + {1'b0, bh};

  assign hit = ({1'b0, ax} < b_right) && ({1'b0, bx} < a_right) &&
               ({1'b0, ay} < b_bottom) && ({1'b0, by} < a_bottom);

endmodule

// File: rtl/brick_field.sv
// Row of breakable bricks: ball collision pulses, brick removal, score,
// cleared-field flag and the brick layer of the VGA pixel stream.
module brick_field import brick_pkg::*; #(
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int BLOCK_W    = DEF_BLOCK_W,
  parameter int BLOCK_H    = DEF_BLOCK_H,
  parameter int ROW_Y      = DEF_ROW_Y,
  parameter int X0         = DEF_X0,
  parameter int PITCH      = DEF_PITCH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  active_pixels,
  input  logic [9:0]            ball_x,
  input  logic [9:0]            ball_y,
  input  logic [9:0]            ball_width,
  input  logic [9:0]            ball_height,
  input  logic                  restart,
  output logic [NUM_BLOCKS-1:0] collide_block,
  output logic [9:0]            block_x,
  output logic [9:0]            block_y,
  output logic [9:0]            block_width,
  output logic [9:0]            block_height,
  output logic [23:0]           vga_color,
  output logic [7:0]            score,
  output logic [3:0]            blocks_left,
  output logic                  field_clear,
  output state_t                state_dbg
);

  state_t                state, state_next;
  logic [NUM_BLOCKS-1:0] alive, overlap, hits, alive_next;
  logic [3:0]            hit_cnt, alive_cnt;
  logic [9:0]            hit_x;
  logic [8:0]            score_sum;

  assign block_width  = 10'(BLOCK_W);
  assign block_height = 10'(BLOCK_H);
  assign state_dbg    = state;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_ov
    rect_overlap u_ov (
      .ax  (ball_x),
      .ay  (ball_y),
      .aw  (ball_width),
      .ah  (ball_height),
      .bx  (brick_x(i, X0, PITCH)),
      .by  (10'(ROW_Y)),
      .bw  (10'(BLOCK_W)),
      .bh  (10'(BLOCK_H)),
      .hit (overlap[i])
    );
  end

  // restart masks hits entirely; walking down the index leaves the lowest hit in hit_x.
  always_comb begin
    hits = '0;
    if (state == PLAY && !restart) hits = overlap & alive;
    alive_next = restart ? '1 : (alive & ~hits);
    hit_cnt    = '0;
    alive_cnt  = '0;
    hit_x      = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      hit_cnt   = hit_cnt + 4'(hits[i]);
      alive_cnt = alive_cnt + 4'(alive_next[i]);
      if (hits[i]) hit_x = brick_x(i, X0, PITCH);
    end
    score_sum  = {1'b0, score} + {5'b0, hit_cnt};
    state_next = state;
    if (restart)                 state_next = PLAY;
    else if (alive_next == '0)   state_next = CLEAR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PLAY;
      alive         <= '1;
      collide_block <= '0;
      block_x       <= '0;
      block_y       <= '0;
      score         <= '0;
      blocks_left   <= 4'(NUM_BLOCKS);
      field_clear   <= 1'b0;
    end else begin
      state         <= state_next;
      alive         <= alive_next;
      collide_block <= hits;
      if (|hits) begin
        block_x <= hit_x;
        block_y <= 10'(ROW_Y);
      end
      score         <= score_sum[8] ? 8'hff : score_sum[7:0];
      blocks_left   <= alive_cnt;
      field_clear   <= (state_next == CLEAR);
    end
  end

  always_comb begin
    vga_color = COLOR_BLACK;
    if (active_pixels) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (alive[i] &&
            ({1'b0, x} >= {1'b0, brick_x(i, X0, PITCH)}) &&
            ({1'b0, x} <  {1'b0, brick_x(i, X0, PITCH)} + 11'(BLOCK_W)) &&
            ({1'b0, y} >= 11'(ROW_Y)) &&
            ({1'b0, y} <  11'(ROW_Y + BLOCK_H)))
          vga_color = ((i % 2) == 0) ? COLOR_EVEN : COLOR_ODD;
      end
    end
  end

endmodule

// File: tb/tb_brick_field.sv
// Directed scenarios plus a randomized run of the brick row against a
// behavioural model of brick life, score and pixel colour.
module tb_brick_field;
  import brick_pkg::*;

  localparam int NB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    x, y;
  logic          active_pixels;
  logic [9:0]    ball_x, ball_y, ball_width, ball_height;
  logic          restart;
  logic [NB-1:0] collide_block;
  logic [9:0]    block_x, block_y, block_width, block_height;
  logic [23:0]   vga_color;
  logic [7:0]    score;
  logic [3:0]    blocks_left;
  logic          field_clear;
  state_t        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  bit            m_alive[NB];
  int            m_score, m_bx, m_by;
  bit            m_clear;
  logic [NB-1:0] m_pulse;

  brick_field dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
    .ball_x(ball_x), .ball_y(ball_y), .ball_width(ball_width), .ball_height(ball_height),
    .restart(restart), .collide_block(collide_block), .block_x(block_x), .block_y(block_y),
    .block_width(block_width), .block_height(block_height), .vga_color(vga_color),
    .score(score), .blocks_left(blocks_left), .field_clear(field_clear), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int left_edge(int i);
    return 2 + i * 64;
  endfunction

  function automatic int model_left();
    int n = 0;
    for (int i = 0; i < NB; i++) n += m_alive[i];
    return n;
  endfunction

  function automatic logic [23:0] model_color(int px, int py, bit act);
    if (!act) return 24'h000000;
    for (int i = 0; i < NB; i++)
      if (m_alive[i] && px >= left_edge(i) && px < left_edge(i) + 60 && py >= 40 && py < 60)
        return (i % 2 == 0) ? 24'hff4000 : 24'h00a0ff;
    return 24'h000000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_alive[i] = 1'b1;
    m_score = 0; m_bx = 0; m_by = 0; m_clear = 1'b0; m_pulse = '0;
  endtask

  task automatic model_step(int bx, int by, int bw, int bh, bit rs);
    int  cnt = 0;
    bit  first = 1'b1;
    m_pulse = '0;
    if (rs) begin
      for (int i = 0; i < NB; i++) m_alive[i] = 1'b1;
      m_clear = 1'b0;
    end else if (!m_clear) begin
      for (int i = 0; i < NB; i++) begin
        if (m_alive[i] && bx < left_edge(i) + 60 && left_edge(i) < bx + bw &&
            by < 60 && 40 < by + bh) begin
          m_pulse[i] = 1'b1;
          m_alive[i] = 1'b0;
          cnt++;
          if (first) begin m_bx = left_edge(i); m_by = 40; first = 1'b0; end
        end
      end
      m_score = (m_score + cnt > 255) ? 255 : m_score + cnt;
      if (model_left() == 0) m_clear = 1'b1;
    end
  endtask

  // Driver tasks
  task automatic step(int bx, int by, int bw, int bh, bit rs);
    ball_x = 10'(bx); ball_y = 10'(by); ball_width = 10'(bw); ball_height = 10'(bh);
    restart = rs;
    model_step(bx, by, bw, bh, rs);
    tick();
  endtask

  task automatic do_reset();
    ball_x = 10'd0; ball_y = 10'd500; ball_width = 10'd4; ball_height = 10'd4;
    restart = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    if (blocks_left !== 4'd10) begin n_fail++; $display("FAIL reset_left got %0d exp 10", blocks_left); end
    n_checks++;
    if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score got %0d exp 0", score); end
    n_checks++;
    if (collide_block !== '0) begin n_fail++; $display("FAIL reset_collide got %b exp 0", collide_block); end
    n_checks++;
    if (field_clear !== 1'b0 || state_dbg !== PLAY) begin n_fail++; $display("FAIL reset_fsm got clear=%b st=%0d", field_clear, state_dbg); end
    n_checks++;
    if (block_x !== 10'd0 || block_y !== 10'd0 || block_width !== 10'd60 || block_height !== 10'd20) begin
      n_fail++; $display("FAIL reset_geom got %0d %0d %0d %0d exp 0 0 60 20", block_x, block_y, block_width, block_height);
    end
    n_checks++;
  endtask

  task automatic test_pixels();
    active_pixels = 1'b1; x = 10'd10; y = 10'd45; #1;
    if (vga_color !== 24'hff4000) begin n_fail++; $display("FAIL pix_even got %h exp ff4000", vga_color); end
    n_checks++;
    x = 10'd70; #1;
    if (vga_color !== 24'h00a0ff) begin n_fail++; $display("FAIL pix_odd got %h exp 00a0ff", vga_color); end
    n_checks++;
    x = 10'd63; #1;
    if (vga_color !== 24'h000000) begin n_fail++; $display("FAIL pix_gap got %h exp 0", vga_color); end
    n_checks++;
    x = 10'd10; active_pixels = 1'b0; #1;
    if (vga_color !== 24'h000000) begin n_fail++; $display("FAIL pix_blank got %h exp 0", vga_color); end
    n_checks++;
    active_pixels = 1'b1;
  endtask

  task automatic test_single_hit();
    do_reset();
    step(80, 55, 20, 20, 1'b0);
    if (collide_block !== 10'b0000000010) begin n_fail++; $display("FAIL hit1_pulse got %b exp 0000000010", collide_block); end
    n_checks++;
    if (block_x !== 10'd66 || block_y !== 10'd40) begin n_fail++; $display("FAIL hit1_geom got %0d,%0d exp 66,40", block_x, block_y); end
    n_checks++;
    if (score !== 8'd1 || blocks_left !== 4'd9) begin n_fail++; $display("FAIL hit1_count got score=%0d left=%0d exp 1,9", score, blocks_left); end
    n_checks++;
    x = 10'd70; y = 10'd45; #1;
    if (vga_color !== 24'h000000) begin n_fail++; $display("FAIL hit1_pixel got %h exp 0", vga_color); end
    n_checks++;
    for (int k = 0; k < 3; k++) begin
      step(80, 55, 20, 20, 1'b0);
      if (collide_block !== '0 || score !== 8'd1) begin n_fail++; $display("FAIL hit1_hold got %b score=%0d exp 0,1", collide_block, score); end
      n_checks++;
    end
  endtask

  task automatic test_double_hit();
    do_reset();
    step(55, 50, 20, 20, 1'b0);
    if (collide_block !== 10'b0000000011) begin n_fail++; $display("FAIL hit2_pulse got %b exp 0000000011", collide_block); end
    n_checks++;
    if (block_x !== 10'd2 || score !== 8'd2 || blocks_left !== 4'd8) begin
      n_fail++; $display("FAIL hit2_state got bx=%0d score=%0d left=%0d exp 2,2,8", block_x, score, blocks_left);
    end
    n_checks++;
    // Ball whose right edge passes 1023: must still overlap brick 9
    step(600, 45, 500, 10, 1'b0);
    if (collide_block !== 10'b1000000000 || block_x !== 10'd578) begin
      n_fail++; $display("FAIL hit_wide got %b bx=%0d exp 1000000000,578", collide_block, block_x);
    end
    n_checks++;
  endtask

  task automatic test_clear_all();
    do_reset();
    for (int i = 0; i < NB; i++) begin
      step(left_edge(i) + 10, 45, 4, 4, 1'b0);
      if (collide_block !== (10'd1 << i)) begin n_fail++; $display("FAIL clr_pulse%0d got %b", i, collide_block); end
      n_checks++;
      if (field_clear !== (i == NB - 1)) begin n_fail++; $display("FAIL clr_flag%0d got %b exp %b", i, field_clear, i == NB - 1); end
      n_checks++;
    end
    if (blocks_left !== 4'd0 || state_dbg !== CLEAR) begin n_fail++; $display("FAIL clr_left got %0d st=%0d exp 0,CLEAR", blocks_left, state_dbg); end
    n_checks++;
    step(0, 500, 4, 4, 1'b0);
    if (field_clear !== 1'b1 || collide_block !== '0) begin n_fail++; $display("FAIL clr_hold got %b %b exp 1,0", field_clear, collide_block); end
    n_checks++;
    step(0, 500, 4, 4, 1'b1);
    if (blocks_left !== 4'd10 || score !== 8'd10 || field_clear !== 1'b0) begin
      n_fail++; $display("FAIL clr_restart got left=%0d score=%0d clear=%b exp 10,10,0", blocks_left, score, field_clear);
    end
    n_checks++;
  endtask

  task automatic test_restart_priority();
    do_reset();
    step(80, 55, 20, 20, 1'b1);
    if (collide_block !== '0 || score !== 8'd0 || blocks_left !== 4'd10) begin
      n_fail++; $display("FAIL rstrt_prio got %b score=%0d left=%0d exp 0,0,10", collide_block, score, blocks_left);
    end
    n_checks++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 7; i++) step(left_edge(i) + 10, 45, 4, 4, 1'b0);
    if (score !== 8'd7) begin n_fail++; $display("FAIL mid_score got %0d exp 7", score); end
    n_checks++;
    ball_x = 10'(left_edge(7) + 10); ball_y = 10'd45; restart = 1'b1; rst = 1'b1;
    tick();
    if (collide_block !== '0 || block_x !== 10'd0 || block_y !== 10'd0 || score !== 8'd0 ||
        blocks_left !== 4'd10 || field_clear !== 1'b0 || state_dbg !== PLAY) begin
      n_fail++; $display("FAIL mid_rst got c=%b bx=%0d by=%0d s=%0d l=%0d f=%b", collide_block, block_x, block_y, score, blocks_left, field_clear);
    end
    n_checks++;
    rst = 1'b0; restart = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int bx, by, bw, bh;
    bit rs;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bx = $urandom_range(0, 660);
      by = $urandom_range(0, 100);
      bw = ($urandom_range(0, 15) == 0) ? $urandom_range(100, 1023) : $urandom_range(1, 40);
      bh = $urandom_range(1, 30);
      rs = ($urandom_range(0, 15) == 0);
      x = 10'($urandom_range(0, 700));
      y = 10'($urandom_range(30, 70));
      active_pixels = ($urandom_range(0, 7) != 0);
      step(bx, by, bw, bh, rs);
      if (collide_block !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse k=%0d got %b exp %b", k, collide_block, m_pulse); end
      n_checks++;
      if (block_x !== 10'(m_bx) || block_y !== 10'(m_by)) begin n_fail++; $display("FAIL rnd_geom k=%0d got %0d,%0d exp %0d,%0d", k, block_x, block_y, m_bx, m_by); end
      n_checks++;
      if (score !== 8'(m_score) || blocks_left !== 4'(model_left())) begin
        n_fail++; $display("FAIL rnd_count k=%0d got %0d,%0d exp %0d,%0d", k, score, blocks_left, m_score, model_left());
      end
      n_checks++;
      if (field_clear !== m_clear) begin n_fail++; $display("FAIL rnd_clear k=%0d got %b exp %b", k, field_clear, m_clear); end
      n_checks++;
      if (vga_color !== model_color(int'(x), int'(y), active_pixels)) begin
        n_fail++; $display("FAIL rnd_color k=%0d got %h exp %h", k, vga_color, model_color(int'(x), int'(y), active_pixels));
      end
      n_checks++;
    end
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; x = '0; y = '0; active_pixels = 1'b0;
    ball_x = '0; ball_y = 10'd500; ball_width = 10'd4; ball_height = 10'd4;
    tick();
    test_reset();
    test_pixels();
    test_single_hit();
    test_double_hit();
    test_clear_all();
    test_restart_priority();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/brick_field.md
# brick_field

Owns the row of breakable bricks for the game. Each cycle it compares the live ball rectangle from the ball module against every surviving brick and emits one-cycle `collide_block` pulses. It also reports the struck brick's geometry, removes struck bricks, keeps score and flags a cleared field. It also drives the brick layer of the VGA pixel stream, which the top level ORs with the ball and paddle layers.

## Interface
- `NUM_BLOCKS`, 10: bricks in the row; 1..10.
- `BLOCK_W`, 60: brick width in pixels.
- `BLOCK_H`, 20: brick height in pixels.
- `ROW_Y`, 40: top edge of the row.
- `X0`, 2: left edge of brick 0.
- `PITCH`, 64: x distance between brick left edges. Brick i spans x in [X0+i·PITCH, X0+i·PITCH+BLOCK_W).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `x`, `y` in 10 each: current VGA pixel coordinate.
- `active_pixels` in 1: VGA display-enable.
- `ball_x`, `ball_y`, `ball_width`, `ball_height` in 10 each: ball rectangle.
- `restart` in 1: one-cycle pulse that reloads all bricks.
- `collide_block` out NUM_BLOCKS: one-cycle hit pulse, one bit per brick.
- `block_x`, `block_y`, `block_width`, `block_height` out 10 each: geometry of the most recently hit brick.
- `vga_color` out 24: brick layer colour.
- `score` out 8: bricks destroyed; saturates at 255.
- `blocks_left` out 4: count of alive bricks.
- `field_clear` out 1: high while no bricks remain.

## Operation
- State `alive[NUM_BLOCKS-1:0]`, all ones after reset.
- Overlap for brick i:
  - `alive[i]`, and
  - ball_x < bx_i+BLOCK_W, and bx_i < ball_x+ball_width, and
  - ball_y < ROW_Y+BLOCK_H, and ROW_Y < ball_y+ball_height.
  - All sums are evaluated at 11 bits so nothing wraps.
- FSM, two states:
  - PLAY (reset state): on each clock, every brick with overlap sets its `collide_block` bit for one cycle and clears its `alive` bit. When `alive` becomes zero, go to CLEAR.
  - CLEAR: `field_clear`=1; there are no hits, so `collide_block`=0. `restart` reloads `alive` to all ones and returns to PLAY.
- `restart` in PLAY also reloads `alive` to all ones and stays in PLAY.
- `restart` has priority over hits in the same cycle: no pulse, no score change.
- Several bricks overlapping in the same cycle:
  - All of them pulse and all of them die.
  - `score` adds the count of struck bricks, saturating at 255.
  - `block_x`/`block_y` report the lowest-index struck brick.
- `block_width`/`block_height` are the constants BLOCK_W/BLOCK_H.
- `block_x`/`block_y` hold their value until the next hit.
- Because a struck brick is dead from the next cycle on, a brick can never pulse twice, even though the ball only moves at 60 Hz.
- `score` is cleared only by `rst`; `restart` preserves it (next level).
- `blocks_left` is the population count of `alive`, registered.
- `vga_color` (combinational):
  - 24'h000000 if `active_pixels`=0.
  - Otherwise, on a pixel inside an alive brick: 24'hff4000 for even index, 24'h00a0ff for odd index.
  - Black everywhere else.

## Timing
- Reset values:
  - `alive` = all ones; state = PLAY.
  - `collide_block` = 0, `block_x` = 0, `block_y` = 0.
  - `block_width` = BLOCK_W, `block_height` = BLOCK_H.
  - `score` = 0, `blocks_left` = NUM_BLOCKS, `field_clear` = 0.
- Latency: if the ball overlaps brick i at the edge ending cycle N, then in cycle N+1:
  - `collide_block[i]`=1, `block_x`/`block_y` are updated, `alive[i]`=0;
  - `score`, `blocks_left` and the FSM update in that same cycle, N+1.
- `field_clear` rises in the same cycle that `blocks_left` reaches 0. It falls in the cycle after `restart`.
- `rst` mid-operation overrides everything, including `restart`.
- `vga_color` has zero latency from `x`/`y`/`alive`.

## Structure
- Package `brick_pkg` holds:
  - default geometry constants;
  - both brick colours;
  - the state enum {PLAY, CLEAR};
  - a function returning bx_i.
- Sub-module `rect_overlap`: pure combinational, two 10-bit rectangles in, 11-bit compare, 1-bit hit out. It is instantiated NUM_BLOCKS times for collision. Pixel hit is a point-in-rectangle test done inline.

## Test plan
- Reset, no ball contact: `blocks_left`=10, `score`=0, `collide_block`=0.
  - Pixel (x=10,y=45) gives 24'hff4000.
  - Pixel (x=70,y=45) gives 24'h00a0ff.
  - Pixel (x=63,y=45) is black.
- Ball 20×20 at (80,55) overlaps brick 1:
  - one cycle later `collide_block`=10'b0000000010, `block_x`=66, `block_y`=40, `score`=1, `blocks_left`=9;
  - the bit drops the following cycle and does not re-fire while the ball is held there.
- Ball at (55,50) overlaps bricks 0 and 1:
  - `collide_block`=10'b0000000011, `block_x`=2, `score`=2.
- Clear all 10 bricks one at a time:
  - `field_clear`=1 with the 10th pulse;
  - `restart` then gives `blocks_left`=10, `score`=10, `field_clear`=0.
- `restart` asserted in the same cycle as an overlap:
  - no `collide_block` pulse, `score` unchanged, all bricks alive.
- `rst` asserted mid-game with score 7:
  - all outputs return to their reset values on the next clock.
